// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin scheduler sharing one 32-cycle signed multiplier core
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [63:0]            resp_prod,
  input  logic                   resp_ready,
  output logic                   busy,
  output logic                   mul_rst,
  output logic [31:0]            mul_in1,
  output logic [31:0]            mul_in2,
  input  logic [63:0]            mul_prod
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CAPTURE, ST_RESP} state_t;

  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] job_id_q, job_id_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [63:0]     prod_q, prod_d;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [ID_W-1:0]    win_idx;
  logic [31:0]        win_a, win_b;
  int                 cand;

  // Nearest asserted requester after ptr, wrapping; only offered while idle.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    win_a   = '0;
    win_b   = '0;
    cand    = 0;
    if (state_q == ST_IDLE) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = (int'(ptr_q) + k) % NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && (i == cand) && req_valid[i]) begin
            found    = 1'b1;
            win_idx  = ID_W'(i);
            grant[i] = 1'b1;
            win_a    = req_a[32*i +: 32];
            win_b    = req_b[32*i +: 32];
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    job_id_d = job_id_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    prod_d   = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          ptr_d    = win_idx;
          job_id_d = win_idx;
          cnt_d    = '0;
          op_a_d   = win_a;
          op_b_d   = win_b;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        prod_d  = mul_prod;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_RST;
      job_id_q <= '0;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      job_id_q <= job_id_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
    end
  end

  // Grants are masked while reset is held so nothing is offered before the first edge.
  assign req_ready  = grant & {NUM_REQ{rst}};
  assign busy       = (state_q != ST_IDLE);
  assign mul_rst    = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = job_id_q;
  assign resp_prod  = prod_q;
  assign mul_in1    = op_a_q;
  assign mul_in2    = op_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized bench for mult_share_arbiter with behavioural reference model
module tb_mult_share_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [63:0]    resp_prod;
  logic           resp_ready;
  logic           busy;
  logic           mul_rst;
  logic [31:0]    mul_in1, mul_in2;
  logic [63:0]    mul_prod = 64'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_prod(resp_prod), .resp_ready(resp_ready),
    .busy(busy), .mul_rst(mul_rst), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_prod(mul_prod)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Shared multiplier core: product appears after 32 edges out of reset; unstable operands corrupt it.
  int          core_cnt = 0;
  logic [31:0] core_a = 0, core_b = 0;
  always @(posedge clk) begin
    if (mul_rst) begin
      core_cnt <= 0;
      mul_prod <= 64'hA5A5_5A5A_C3C3_3C3C;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 0) begin
        core_a <= mul_in1;
        core_b <= mul_in2;
      end
      if (core_cnt == 31) begin
        if (mul_in1 == core_a && mul_in2 == core_b)
          mul_prod <= 64'(longint'($signed(mul_in1)) * longint'($signed(mul_in2)));
        else
          mul_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: a job is "age" edges past its accept; response is due from age 34 on.
  bit          m_active = 0;
  int          m_age = 0;
  int          m_id = 0;
  int          m_ptr = N - 1;
  logic [31:0] m_opa = 0, m_opb = 0;
  logic [63:0] m_prod = 0;

  always @(posedge clk or negedge rst) begin
    int w;
    if (!rst) begin
      m_active <= 0; m_age <= 0; m_id <= 0; m_ptr <= N - 1;
      m_opa <= 0; m_opb <= 0; m_prod <= 0;
    end else if (!m_active) begin
      w = rr_pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_active <= 1;
        m_age    <= 1;
        m_id     <= w;
        m_ptr    <= w;
        m_opa    <= req_a[32*w +: 32];
        m_opb    <= req_b[32*w +: 32];
        m_prod   <= 64'(longint'($signed(req_a[32*w +: 32])) * longint'($signed(req_b[32*w +: 32])));
      end
    end else if (m_age >= 34) begin
      if (resp_ready) m_active <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    int w;
    logic [N-1:0] exp_rdy;
    w = rr_pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (rst && !m_active && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_active);
    chk("mul_rst", mul_rst, !m_active || m_age >= 34);
    chk("resp_valid", resp_valid, m_active && m_age >= 34);
    chk("mul_in1", mul_in1, m_opa);
    chk("mul_in2", mul_in2, m_opb);
    if (m_active && m_age >= 34) begin
      chk("resp_id", resp_id, m_id);
      chk("resp_prod", resp_prod, m_prod);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 200) begin
      tick;
      n++;
    end
    if (!resp_valid) chk("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic drain;
    int n;
    resp_ready = 1'b1;
    req_valid  = '0;
    n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    chk("drain", busy, 1'b0);
  endtask

  int          grants[$];
  int          rids[$];
  logic [63:0] rprods[$];
  logic [31:0] ca[4], cb[4];
  logic [63:0] cexp[4];

  initial begin
    int n;
    logic [1:0]  hold_id;
    logic [63:0] hold_prod;
    logic [31:0] spec[5];

    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    rst = 1'b0;

    // reset with every requester asking
    req_valid = '1;
    repeat (3) tick;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    req_valid = 4'b0001;
    set_lane(0, 32'd7, -32'sd3);
    rst = 1'b1;
    #1;
    chk("first_grant", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    wait_resp(n);
    chk("latency", n, 33);
    chk("single_id", resp_id, 0);
    chk("single_prod", resp_prod, 64'hFFFF_FFFF_FFFF_FFEB);
    resp_ready = 1'b1;
    tick;
    chk("idle_after_hs", busy, 0);
    resp_ready = 1'b0;

    // fairness from a fresh pointer
    do_reset;
    set_lane(0, 32'd3, 32'd5);
    set_lane(1, 32'd100, -32'sd100);
    set_lane(2, -32'sd7, 32'd9);
    set_lane(3, 32'd123456, -32'sd654321);
    req_valid = '1;
    resp_ready = 1'b1;
    n = 0;
    while (grants.size() < 5 && n < 300) begin
      #1;
      if (|(req_ready & req_valid)) grants.push_back(oh_idx(req_ready));
      if (resp_valid && resp_ready) begin
        rids.push_back(int'(resp_id));
        rprods.push_back(resp_prod);
      end
      tick;
      n++;
    end
    chk("fair_count", grants.size(), 5);
    if (grants.size() == 5) begin
      chk("fair_g0", grants[0], 0);
      chk("fair_g1", grants[1], 1);
      chk("fair_g2", grants[2], 2);
      chk("fair_g3", grants[3], 3);
      chk("fair_g4", grants[4], 0);
    end
    if (rids.size() >= 2) begin
      chk("fair_r0_id", rids[0], 0);
      chk("fair_r0_prod", rprods[0], 64'd15);
      chk("fair_r1_id", rids[1], 1);
      chk("fair_r1_prod", rprods[1], 64'hFFFF_FFFF_FFFF_D8F0);
    end else begin
      chk("fair_resp_count", rids.size(), 2);
    end
    drain;

    // backpressure: pointer sits at 0, so requester 1 is next
    req_valid = '1;
    resp_ready = 1'b0;
    wait_resp(n);
    hold_id = resp_id;
    hold_prod = resp_prod;
    chk("bp_id", hold_id, 1);
    chk("bp_prod", hold_prod, 64'hFFFF_FFFF_FFFF_D8F0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", resp_valid, 1);
      chk("bp_hold_id", resp_id, hold_id);
      chk("bp_hold_prod", resp_prod, hold_prod);
      chk("bp_no_grant", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick;
    chk("bp_release_idle", busy, 0);
    chk("bp_next_grant", req_ready, 4'b0100);
    req_valid = '0;
    tick;

    // corner operands
    ca[0] = 32'h8000_0000; cb[0] = 32'h8000_0000; cexp[0] = 64'h4000_0000_0000_0000;
    ca[1] = 32'hFFFF_FFFF; cb[1] = 32'hFFFF_FFFF; cexp[1] = 64'h0000_0000_0000_0001;
    ca[2] = 32'h0000_0000; cb[2] = 32'h8000_0000; cexp[2] = 64'h0000_0000_0000_0000;
    ca[3] = 32'h8000_0000; cb[3] = 32'h0000_0001; cexp[3] = 64'hFFFF_FFFF_8000_0000;
    for (int i = 0; i < 4; i++) begin
      set_lane(i, ca[i], cb[i]);
      req_valid = '0;
      req_valid[i] = 1'b1;
      tick;
      req_valid = '0;
      wait_resp(n);
      chk("corner_id", resp_id, i);
      chk("corner_prod", resp_prod, cexp[i]);
      tick;
    end

    // reset while the core is mid-iteration
    set_lane(1, 32'd12345, -32'sd678);
    req_valid = 4'b0010;
    tick;
    req_valid = '0;
    repeat (15) tick;
    rst = 1'b0;
    #1;
    chk("midrst_mul_rst", mul_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    repeat (3) tick;
    set_lane(0, 32'h8000_0000, 32'd3);
    set_lane(2, 32'd5, 32'd6);
    req_valid = 4'b0101;
    rst = 1'b1;
    #1;
    chk("midrst_grant", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    wait_resp(n);
    chk("midrst_id", resp_id, 0);
    chk("midrst_prod", resp_prod, 64'hFFFF_FFFE_8000_0000);
    drain;

    // random traffic against the model
    spec[0] = 32'h0; spec[1] = 32'h1; spec[2] = 32'hFFFF_FFFF;
    spec[3] = 32'h8000_0000; spec[4] = 32'h7FFF_FFFF;
    for (int c = 0; c < 4000; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0)
          set_lane(i, spec[$urandom_range(4)], spec[$urandom_range(4)]);
        else if ($urandom_range(3) == 0)
          set_lane(i, $urandom, $urandom);
      end
      resp_ready = ($urandom_range(3) != 0);
      tick;
    end
    drain;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin scheduler that shares one 32-bit iterative signed multiplier (32-cycle shift/add core) among NUM_REQ requesters. Owns the multiplier's reset, operand inputs and product sampling: it accepts one request, holds operands stable for the full iteration, captures the 64-bit product and returns it with the requester ID over a valid/ready response port. It sits between the requesting datapath blocks and the shared multiplier instance.

## Interface
- NUM_REQ, 4, number of requesters (1..16)
- ID_W, $clog2(NUM_REQ) (min 1), width of resp_id
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_a  input  32*NUM_REQ  signed operand A, requester i at [32*i+31:32*i]
- req_b  input  32*NUM_REQ  signed operand B, same packing
- req_ready  output  NUM_REQ  one-hot grant; accept when req_valid[i] & req_ready[i]
- resp_valid  output  1  product valid
- resp_id  output  ID_W  index of requester that issued the job
- resp_prod  output  64  signed product
- resp_ready  input  1  consumer accepts response
- busy  output  1  high in any state other than IDLE
- mul_rst  output  1  active-high reset to multiplier core
- mul_in1  output  32  operand A to core
- mul_in2  output  32  operand B to core
- mul_prod  input  64  product from core

## Operation
- States: IDLE, BUSY, CAPTURE, RESP.
- IDLE: req_ready is one-hot of the round-robin winner among asserted req_valid, searching from ptr+1 upward with wrap; all-zero if no req_valid. On the accept edge, latch operands into op_a/op_b, latch winner index into job_id, set ptr to winner, clear cnt, go BUSY.
- BUSY: cnt increments each edge 0..31; on the edge with cnt==31 go CAPTURE.
- CAPTURE: one cycle; on its edge latch mul_prod into resp_prod, go RESP.
- RESP: resp_valid=1, resp_id=job_id, resp_prod stable. On resp_valid & resp_ready edge go IDLE.
- req_ready is 0 in BUSY, CAPTURE and RESP. No grant in the same cycle as a response handshake.
- mul_rst = 1 in IDLE and RESP, 0 in BUSY and CAPTURE; decode it from registered state only, no glitching.
- mul_in1/mul_in2 = op_a/op_b, held constant from accept until the next accept. The core derives product sign from its inputs on every edge, so the operands must not change during BUSY or CAPTURE.
- Arithmetic: full 32x32 signed product, 64 bits, no saturation. -2^31 operands give exact results.
- ptr resets to NUM_REQ-1, so requester 0 has first priority. ptr updates only on accept.

## Timing
- Reset values: state IDLE, req_ready 0, resp_valid 0, resp_id 0, resp_prod 0, busy 0, mul_rst 1, mul_in1/mul_in2 0, ptr NUM_REQ-1, cnt 0.
- Latency: accept edge at T0. mul_rst falls after T0. The core runs edges T1..T32 and its product updates at T32. CAPTURE samples at T33. resp_valid is high from T33 until the handshake.
- Minimum job spacing: 35 cycles (1 IDLE + 32 BUSY + 1 CAPTURE + 1 RESP).
- Backpressure: with resp_ready low, stay in RESP indefinitely with outputs stable and no grants.
- Reset mid-operation: async assert forces reset values immediately. The in-flight job is dropped with no response, and the core is reset through mul_rst.
- Requester dropping req_valid before grant: no effect, re-arbitrated each IDLE cycle.
- NUM_REQ=1: grant is always requester 0 when valid.

## Test plan
- Reset: hold rst=0 with all req_valid=1 -> req_ready=0, resp_valid=0, mul_rst=1, busy=0. Release -> req_ready=4'b0001 in the first cycle.
- Single job: req 0, a=7, b=-3 -> accept at T0, resp_valid rises at T0+33, resp_id=0, resp_prod=0xFFFFFFFFFFFFFFEB. Handshake -> busy=0 next cycle.
- Fairness: all 4 req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0. Each response has the matching id and product (e.g. 3*5=15, 100*-100=-10000).
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_prod/resp_id stable, req_ready=0. Release -> IDLE next cycle, then the next grant.
- Corners: 0x80000000*0x80000000=0x4000000000000000; 0xFFFFFFFF*0xFFFFFFFF=1; 0*0x80000000=0; 0x80000000*1=0xFFFFFFFF80000000.
- Reset mid-BUSY: assert rst at cnt=15 -> mul_rst=1 and no response. After release, req 2 and req 0 valid -> req 0 granted first, correct product.
